mem_dump_sender: RTL
====================

Name: mem_dump_sender

Overview:
Parametrised successor to the single-byte memory-to-UART sender FSM. Streams a programmable window of memory words from a synchronous-read RAM to a byte-wide UART transmitter, one byte per tx handshake, LSB byte first. Adds programmable base/count, multi-byte words, configurable RAM read latency, abort, and an optional trailing checksum. Sits between sample RAM and the rs232 transmitter.

Parameters:
ADDR_WIDTH, 16, RAM address width; address wraps mod 2^ADDR_WIDTH.
DATA_WIDTH, 8, RAM word width; must be a multiple of 8; BYTES = DATA_WIDTH/8.
MEM_LATENCY, 1, cycles from oAddress change to valid iData (1..4).

Ports:
iClock  in  1  system clock, rising edge.
iReset  in  1  asynchronous, active-low reset.
iStart  in  1  start request; sampled only in IDLE.
iAbort  in  1  synchronous abort; returns to IDLE, no oFinished.
iBaseAddr  in  ADDR_WIDTH  first word address, latched on accepted start.
iCount  in  ADDR_WIDTH+1  number of words to send, latched on accepted start; 0 allowed.
iData  in  DATA_WIDTH  RAM read data.
iTxDone  in  1  transmitter byte-complete pulse.
oAddress  out  ADDR_WIDTH  RAM read address.
oTxData  out  8  byte to transmit; stable from oTxSend until iTxDone.
oTxSend  out  1  one-cycle send pulse to transmitter.
oBusy  out  1  high in every state except IDLE.
oFinished  out  1  one-cycle pulse after last byte (or checksum) done.

Behaviour:
- Reset (iReset=0, async): state IDLE; oAddress=0, oTxData=0, oTxSend=0, oBusy=0, oFinished=0, internal counters 0.
- States: IDLE, FETCH, LOAD, SEND, WAIT_TX, CHECKSUM (macro only), DONE.
- IDLE: on iStart=1 -> latch base/count, oAddress<=iBaseAddr, byte index 0, clear checksum. count=0 -> DONE directly; else -> FETCH. oAddress holds its last value while idle.
- FETCH: wait MEM_LATENCY cycles after oAddress update, then -> LOAD.
- LOAD: capture iData into word shift register -> SEND.
- SEND: oTxData<=current byte (word[7:0] first), oTxSend=1 for exactly one cycle -> WAIT_TX.
- WAIT_TX: hold oTxData; iTxDone ignored in all other states. On iTxDone: if byte index < BYTES-1: shift word right 8, index+1 -> SEND. Else if words remaining > 1: oAddress<=oAddress+1 (wrap 2^ADDR_WIDTH-1 -> 0), decrement remaining, index 0 -> FETCH. Else -> CHECKSUM (if enabled) or DONE.
- DONE: oFinished=1 for one cycle -> IDLE.
- Count 2^ADDR_WIDTH sends every word exactly once (fixes predecessor's skipped final address).
- iStart while oBusy=1 ignored. iAbort in any non-IDLE state: next cycle IDLE, oTxSend=0, oFinished=0, oAddress holds. iAbort has priority over iTxDone in same cycle.
- iTxDone coincident with oTxSend cycle is ignored (must arrive after SEND).
- Reset mid-transfer: immediate return to reset values; no partial oFinished.

Optional Feature:
Macro CHECKSUM_EN. Defined: running 8-bit sum (mod 256) of all bytes sent; after last data byte, CHECKSUM state sends (~sum+1)&0xFF via the same SEND/WAIT_TX handshake, then DONE. count=0 sends checksum 0x00. Undefined: CHECKSUM state and adder absent; last data byte goes straight to DONE.

Test Plan:
- DATA_WIDTH=8, base=0x0010, count=3, RAM[i]=i, iTxDone 5 cycles after each oTxSend -> bytes 0x10,0x11,0x12, oAddress 0x10..0x12, exactly 3 oTxSend pulses, one oFinished.
- DATA_WIDTH=16, count=2, RAM[0]=0xBEEF, RAM[1]=0x1234 -> bytes EF,BE,34,12 in order.
- Wrap: ADDR_WIDTH=4, base=0xE, count=3 -> oAddress 0xE,0xF,0x0; count=16 sends 16 bytes.
- count=0 -> no oTxSend, oFinished 2 cycles after iStart; with CHECKSUM_EN one byte 0x00 then oFinished.
- iAbort during 2nd WAIT_TX of 4-word dump -> IDLE next cycle, no further oTxSend, no oFinished; iStart during busy ignored.
- CHECKSUM_EN, bytes 0x01,0x02,0x03 -> fourth byte 0xFA; MEM_LATENCY=3 -> LOAD exactly 3 cycles after address change; iReset low mid-send -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_dump_sender_if.sv
// Handshake and data bundle between mem_dump_sender, its sample RAM and the byte transmitter.
// master: the sender side; slave: the RAM/transmitter/controller side.
interface mem_dump_sender_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  iStart;
  logic                  iAbort;
  logic [ADDR_WIDTH-1:0] iBaseAddr;
  logic [ADDR_WIDTH:0]   iCount;
  logic [DATA_WIDTH-1:0] iData;
  logic                  iTxDone;
  logic [ADDR_WIDTH-1:0] oAddress;
  logic [7:0]            oTxData;
  logic                  oTxSend;
  logic                  oBusy;
  logic                  oFinished;

  modport master (
    input  iStart, iAbort, iBaseAddr, iCount, iData, iTxDone,
    output oAddress, oTxData, oTxSend, oBusy, oFinished
  );

  modport slave (
    output iStart, iAbort, iBaseAddr, iCount, iData, iTxDone,
    input  oAddress, oTxData, oTxSend, oBusy, oFinished
  );
endinterface

// File: rtl/mem_dump_sender.sv
// Streams a window of RAM words to a byte-wide transmitter, LSB byte first.
// Define CHECKSUM_EN to append a two's-complement 8-bit checksum byte after the data.
module mem_dump_sender #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic               iClock,
  input logic               iReset,
  mem_dump_sender_if.master bus
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [IdxW-1:0]     LastIdx = IdxW'(BYTES - 1);
  localparam logic [2:0]          LatLast = 3'(MEM_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] CntOne  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StSend,
    StWaitTx,
`ifdef CHECKSUM_EN
    StChecksum,
`endif
    StDone
  } state_e;

`ifdef CHECKSUM_EN
  localparam state_e StAfterData = StChecksum;
`else
  localparam state_e StAfterData = StDone;
`endif

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [IdxW-1:0]       idx_q;
  logic [2:0]            lat_q;
  logic [7:0]            tx_data_q;
  logic                  tx_send_q;
  logic                  busy_q;
  logic                  fin_q;
`ifdef CHECKSUM_EN
  logic [7:0]            sum_q;
  logic                  cks_q;
`endif

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      remain_q  <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      lat_q     <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q     <= '0;
      cks_q     <= 1'b0;
`endif
    end else begin
      tx_send_q <= 1'b0;
      fin_q     <= 1'b0;
      // Abort wins over everything, including a same-cycle iTxDone; oAddress holds.
      if (bus.iAbort && (state_q != StIdle)) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
        lat_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.iStart) begin
              addr_q   <= bus.iBaseAddr;
              remain_q <= bus.iCount;
              idx_q    <= '0;
              lat_q    <= '0;
              busy_q   <= 1'b1;
`ifdef CHECKSUM_EN
              sum_q    <= '0;
              cks_q    <= 1'b0;
`endif
              state_q  <= (bus.iCount == '0) ? StAfterData : StFetch;
            end
          end
          StFetch: begin
            if (lat_q == LatLast) begin
              lat_q   <= '0;
              state_q <= StLoad;
            end else begin
              lat_q <= lat_q + 3'd1;
            end
          end
          StLoad: begin
            word_q  <= bus.iData;
            state_q <= StSend;
          end
          StSend: begin
            tx_data_q <= word_q[7:0];
            tx_send_q <= 1'b1;
`ifdef CHECKSUM_EN
            sum_q     <= sum_q + word_q[7:0];
`endif
            state_q   <= StWaitTx;
          end
          StWaitTx: begin
            // A done pulse in the same cycle as our send pulse belongs to an earlier byte.
            if (bus.iTxDone && !tx_send_q) begin
`ifdef CHECKSUM_EN
              if (cks_q) begin
                state_q <= StDone;
              end else
`endif
              if (idx_q != LastIdx) begin
                word_q  <= word_q >> 8;
                idx_q   <= idx_q + IdxW'(1);
                state_q <= StSend;
              end else if (remain_q > CntOne) begin
                addr_q   <= addr_q + ADDR_WIDTH'(1);
                remain_q <= remain_q - CntOne;
                idx_q    <= '0;
                state_q  <= StFetch;
              end else begin
                state_q <= StAfterData;
              end
            end
          end
`ifdef CHECKSUM_EN
          StChecksum: begin
            // Reuse the data send path; index at last byte makes WAIT_TX finish after it.
            word_q      <= '0;
            word_q[7:0] <= 8'd0 - sum_q;
            idx_q       <= LastIdx;
            cks_q       <= 1'b1;
            state_q     <= StSend;
          end
`endif
          StDone: begin
            fin_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.oAddress  = addr_q;
  assign bus.oTxData   = tx_data_q;
  assign bus.oTxSend   = tx_send_q;
  assign bus.oBusy     = busy_q;
  assign bus.oFinished = fin_q;

endmodule
